// File: rtl/moving_average_var.sv
// Variable-length moving average over the last 2^P samples (P = clamped power_sel).
// Define MOVING_AVERAGE_VAR_ROUND_EN for round-half-up output instead of truncation.
module moving_average_var #(
  parameter int DATA_W    = 10,
  parameter int MAX_POWER = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strobe_in,
  input  logic [2:0]        power_sel,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              filled
);

  localparam int          DEPTH = 1 << MAX_POWER;
  localparam int          SUM_W = DATA_W + MAX_POWER;
  localparam int          PTR_W = MAX_POWER;
  localparam logic [2:0]  MAX_P = 3'(MAX_POWER);

  logic [DATA_W-1:0] sample_buf [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [SUM_W-1:0]  sum;
  logic [2:0]        p;
  logic [PTR_W:0]    fill_cnt;

  logic [2:0]        eff_p;
  logic [2:0]        out_p;
  logic              reload;
  logic [PTR_W:0]    win_len;
  logic [PTR_W-1:0]  rd_idx;
  logic [SUM_W-1:0]  new_sum;
`ifdef MOVING_AVERAGE_VAR_ROUND_EN
  logic [SUM_W:0]    rnd_inc;
`endif

  always_comb begin
    eff_p   = (power_sel > MAX_P) ? MAX_P : power_sel;
    reload  = (eff_p != p);
    out_p   = reload ? eff_p : p;
    win_len = (PTR_W+1)'(1) << p;
    // At P == MAX_POWER the offset wraps to 0, so the slot about to be
    // overwritten is exactly the oldest sample leaving the window.
    rd_idx  = wr_ptr - win_len[PTR_W-1:0];
    if (reload)
      new_sum = SUM_W'(data_in);
    else
      new_sum = sum + SUM_W'(data_in) - SUM_W'(sample_buf[rd_idx]);
`ifdef MOVING_AVERAGE_VAR_ROUND_EN
    rnd_inc = '0;
    if (out_p != 3'd0)
      rnd_inc = (SUM_W+1)'(1) << (out_p - 3'd1);
`endif
  end

  assign filled = (fill_cnt == win_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        sample_buf[i] <= '0;
      wr_ptr     <= '0;
      sum        <= '0;
      p          <= '0;
      fill_cnt   <= '0;
      data_out   <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= 1'b0;
      if (clear) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          sample_buf[i] <= '0;
        wr_ptr   <= '0;
        sum      <= '0;
        fill_cnt <= '0;
      end else if (strobe_in) begin
        // A power change flushes history; the new sample's write below
        // overrides the flush of its own slot.
        if (reload)
          for (int unsigned i = 0; i < DEPTH; i++)
            sample_buf[i] <= '0;
        sample_buf[wr_ptr] <= data_in;
        wr_ptr <= wr_ptr + PTR_W'(1);
        sum    <= new_sum;
        p      <= out_p;
        if (reload)
          fill_cnt <= (PTR_W+1)'(1);
        else if (fill_cnt != win_len)
          fill_cnt <= fill_cnt + (PTR_W+1)'(1);
`ifdef MOVING_AVERAGE_VAR_ROUND_EN
        data_out <= DATA_W'(({1'b0, new_sum} + rnd_inc) >> out_p);
`else
        data_out <= DATA_W'(new_sum >> out_p);
`endif
        strobe_out <= 1'b1;
      end
    end
  end

endmodule
